// File: rtl/dac_cfg_pkg.sv
// Shared definitions for the DAC command sequencer: FSM encoding, command
// word field positions and default timing parameters.
package dac_cfg_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP,
        ST_GAP
    } seq_state_e;

    localparam int DEF_TIMEOUT_CYCLES = 16384;
    localparam int DEF_GAP_CYCLES     = 16;

    // One FIFO entry carries the host address above the command word
    localparam int CMD_ENTRY_W = 64;

    // DAC command word layout; the [31:28] command nibble is not used by the DAC
    localparam int CMD_NIB_MSB  = 31;
    localparam int CMD_NIB_LSB  = 28;
    localparam int REG_ADDR_MSB = 19;
    localparam int REG_ADDR_LSB = 16;
    localparam int REG_VAL_MSB  = 15;
    localparam int REG_VAL_LSB  = 4;

    function automatic logic [3:0] dac_reg_addr(input logic [31:0] cmd);
        return cmd[REG_ADDR_MSB:REG_ADDR_LSB];
    endfunction

    function automatic logic [11:0] dac_reg_val(input logic [31:0] cmd);
        return cmd[REG_VAL_MSB:REG_VAL_LSB];
    endfunction

endpackage

// File: rtl/dac_cmd_fifo.sv
// First-word-fall-through command FIFO; head always shows the oldest entry
// while level is non-zero.
module dac_cmd_fifo
    import dac_cfg_pkg::*;
#(
    parameter int WIDTH   = CMD_ENTRY_W,
    parameter int DEPTH   = 8,
    parameter int LEVEL_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   head,
    output logic [LEVEL_W-1:0] level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is still legal when the head leaves in the same cycle
    assign do_pop  = pop && (level != '0);
    assign do_push = push && ((level != LEVEL_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LEVEL_W'(do_push) - LEVEL_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dac_cmd_sequencer.sv
// Buffers host DAC command writes and forwards them one at a time to the DAC
// configuration block, pacing issues on response, timeout and a SYNC gap.
module dac_cmd_sequencer
    import dac_cfg_pkg::*;
#(
    parameter logic [31:0] CONFIG_BASE_ADDR = 32'h0010,
    parameter int          FIFO_DEPTH       = 8,
    parameter int          TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
    parameter int          GAP_CYCLES       = DEF_GAP_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_wr_valid,
    input  logic [31:0] host_wr_addr,
    input  logic [31:0] host_wr_data,
    output logic        host_wr_ready,
    input  logic        dac_done,
    output logic        cfg_valid,
    output logic [31:0] cfg_addr,
    output logic [31:0] cfg_data,
    input  logic        cfg_rsp_valid,
    input  logic [31:0] cfg_rsp_data,
    output logic [31:0] last_rsp,
    output logic [6:0]  fifo_level,
    output logic        busy,
    output logic        timeout_err,
    output logic        overflow_err,
    input  logic        err_clr
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(GAP_CYCLES);
    localparam logic [6:0]       DEPTH_L  = 7'(FIFO_DEPTH);

    seq_state_e       state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [63:0]      head;
    logic [6:0]       level_next;
    logic             accept;
    logic             full;
    logic             push;
    logic             pop;
    logic             overflow_evt;
    logic             timeout_evt;

    assign accept       = host_wr_valid && (host_wr_addr[6:4] == CONFIG_BASE_ADDR[6:4]);
    assign full         = (fifo_level == DEPTH_L);
    assign pop          = (state == ST_IDLE) && (fifo_level != 7'd0);
    assign push         = accept && (!full || pop);
    assign overflow_evt = accept && full && !pop;
    assign timeout_evt  = (state == ST_WAIT_RSP) && !cfg_rsp_valid && (tmo_cnt == TMO_LAST);
    assign level_next   = fifo_level + 7'(push) - 7'(pop);
    assign busy         = (fifo_level != 7'd0) || (state == ST_ISSUE) ||
                          (state == ST_WAIT_RSP) || (state == ST_GAP);

    dac_cmd_fifo #(
        .WIDTH   (CMD_ENTRY_W),
        .DEPTH   (FIFO_DEPTH),
        .LEVEL_W (7)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({host_wr_addr, host_wr_data}),
        .pop       (pop),
        .head      (head),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT;
            cfg_valid <= 1'b0;
            cfg_addr  <= '0;
            cfg_data  <= '0;
            last_rsp  <= '0;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (dac_done)
                        state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (pop) begin
                        cfg_addr  <= head[63:32];
                        cfg_data  <= head[31:0];
                        cfg_valid <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cfg_valid <= 1'b0;
                    tmo_cnt   <= '0;
                    state     <= ST_WAIT_RSP;
                end
                ST_WAIT_RSP: begin
                    // A response arriving on the last allowed cycle still counts as a response
                    if (cfg_rsp_valid) begin
                        last_rsp <= cfg_rsp_data;
                        gap_cnt  <= '0;
                        state    <= ST_GAP;
                    end else if (timeout_evt) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end else if (tmo_cnt != TMO_MAX) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state <= ST_IDLE;
                    else if (gap_cnt != GAP_MAX)
                        gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Sticky errors: a fresh event outranks a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err   <= 1'b0;
            overflow_err  <= 1'b0;
            host_wr_ready <= 1'b1;
        end else begin
            if (timeout_evt)
                timeout_err <= 1'b1;
            else if (err_clr)
                timeout_err <= 1'b0;
            if (overflow_evt)
                overflow_err <= 1'b1;
            else if (err_clr)
                overflow_err <= 1'b0;
            host_wr_ready <= (level_next != DEPTH_L);
        end
    end

endmodule

// File: tb/tb_dac_cmd_sequencer.sv
// Directed bench for dac_cmd_sequencer: expected commands go into a scoreboard
// queue and a negedge monitor checks every cfg_valid strobe against it.
module tb_dac_cmd_sequencer;

    localparam int T   = 16384;
    localparam int GAP = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_wr_valid = 1'b0;
    logic [31:0] host_wr_addr = '0;
    logic [31:0] host_wr_data = '0;
    logic        host_wr_ready;
    logic        dac_done = 1'b0;
    logic        cfg_valid;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_rsp_valid = 1'b0;
    logic [31:0] cfg_rsp_data = '0;
    logic [31:0] last_rsp;
    logic [6:0]  fifo_level;
    logic        busy;
    logic        timeout_err;
    logic        overflow_err;
    logic        err_clr = 1'b0;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          pulse_cnt = 0;
    int          pulse_cyc = 0;
    int          rsp_cyc = 0;
    logic        prev_valid = 1'b0;
    logic [63:0] sb[$];

    dac_cmd_sequencer #(
        .CONFIG_BASE_ADDR (32'h0010),
        .FIFO_DEPTH       (8),
        .TIMEOUT_CYCLES   (T),
        .GAP_CYCLES       (GAP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .host_wr_valid (host_wr_valid),
        .host_wr_addr  (host_wr_addr),
        .host_wr_data  (host_wr_data),
        .host_wr_ready (host_wr_ready),
        .dac_done      (dac_done),
        .cfg_valid     (cfg_valid),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .cfg_rsp_valid (cfg_rsp_valid),
        .cfg_rsp_data  (cfg_rsp_data),
        .last_rsp      (last_rsp),
        .fifo_level    (fifo_level),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .overflow_err  (overflow_err),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expected command
    always @(negedge clk) begin
        if (cfg_valid) begin
            pulse_cnt++;
            pulse_cyc = cyc;
            check("cfg_valid_width", {63'd0, prev_valid}, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_cfg_valid", {cfg_addr, cfg_data}, 64'd0);
            end else begin
                logic [63:0] exp;
                exp = sb.pop_front();
                check("cfg_addr", {32'd0, cfg_addr}, {32'd0, exp[63:32]});
                check("cfg_data", {32'd0, cfg_data}, {32'd0, exp[31:0]});
            end
        end
        prev_valid = cfg_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit expect_issue);
        host_wr_valid = 1'b1;
        host_wr_addr  = a;
        host_wr_data  = d;
        if (expect_issue)
            sb.push_back({a, d});
        tick();
        host_wr_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int target, input int budget);
        int n = 0;
        while (pulse_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (pulse_cnt < target)
            check("cfg_valid_wait_timeout", 64'(pulse_cnt), 64'(target));
    endtask

    task automatic respond(input logic [31:0] d, input int delay);
        repeat (delay) tick();
        cfg_rsp_valid = 1'b1;
        cfg_rsp_data  = d;
        rsp_cyc       = cyc;
        tick();
        cfg_rsp_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_valid"}, 64'(cfg_valid), 64'd0);
        check({tag, "_cfg_addr"}, 64'(cfg_addr), 64'd0);
        check({tag, "_cfg_data"}, 64'(cfg_data), 64'd0);
        check({tag, "_last_rsp"}, 64'(last_rsp), 64'd0);
        check({tag, "_fifo_level"}, 64'(fifo_level), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
        check({tag, "_overflow_err"}, 64'(overflow_err), 64'd0);
        check({tag, "_host_wr_ready"}, 64'(host_wr_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        int np;

        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Commands queue up while the DAC is still auto-configuring
        wr(32'h0000_0010, 32'h1001_0AB0, 1'b1);
        wr(32'h0000_0014, 32'h1002_0CD0, 1'b1);
        wr(32'h0000_001C, 32'h1003_0EF0, 1'b1);
        repeat (20) tick();
        check("init_fifo_level", 64'(fifo_level), 64'd3);
        check("init_no_issue", 64'(pulse_cnt), 64'd0);
        check("init_busy", 64'(busy), 64'd1);
        dac_done = 1'b1;
        tick();
        dac_done = 1'b0;

        wait_pulse(1, 50);
        respond(32'hA5A5_A5A5, 3);
        check("last_rsp_first", 64'(last_rsp), 64'hA5A5_A5A5);
        wait_pulse(2, 60);
        check("issue2_after_gap", 64'(pulse_cyc), 64'(rsp_cyc + GAP + 2));
        respond(32'h1234_5678, 0);
        wait_pulse(3, 60);
        check("issue3_after_gap", 64'(pulse_cyc), 64'(rsp_cyc + GAP + 2));
        respond(32'h0BAD_F00D, 7);
        check("last_rsp_third", 64'(last_rsp), 64'h0BAD_F00D);
        repeat (GAP + 4) tick();
        check("drained_level", 64'(fifo_level), 64'd0);
        check("drained_busy", 64'(busy), 64'd0);

        // A response strobe outside WAIT_RSP must not touch last_rsp
        respond(32'hDEAD_BEEF, 0);
        tick();
        check("stray_rsp_ignored", 64'(last_rsp), 64'h0BAD_F00D);

        // Address outside the DAC window (bits [6:4] = 010)
        np = pulse_cnt;
        wr(32'h0000_0020, 32'h0039_C000, 1'b0);
        repeat (8) tick();
        check("ignored_level", 64'(fifo_level), 64'd0);
        check("ignored_no_issue", 64'(pulse_cnt), 64'(np));

        // Write at cycle N into an empty, idle FIFO strobes at N+2; then let it time out
        pc = cyc;
        wr(32'h0000_0018, 32'h1004_0120, 1'b1);
        wait_pulse(np + 1, 10);
        check("issue_latency", 64'(pulse_cyc), 64'(pc + 2));
        pc = pulse_cyc;
        wr(32'h0000_0010, 32'h1005_0340, 1'b1);
        while (cyc < pc + T) tick();
        check("timeout_not_yet", 64'(timeout_err), 64'd0);
        tick();
        check("timeout_asserted", 64'(timeout_err), 64'd1);
        wait_pulse(np + 2, 40);
        check("issue_after_timeout", 64'(pulse_cyc), 64'(pc + T + GAP + 2));
        respond(32'h5A5A_0001, 2);
        check("timeout_sticky", 64'(timeout_err), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("timeout_cleared", 64'(timeout_err), 64'd0);
        repeat (GAP + 4) tick();

        // Overflow with the DAC held in INIT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);
        for (int i = 0; i < 9; i++) begin
            if (i == 7) check("ready_before_full", 64'(host_wr_ready), 64'd1);
            if (i == 8) check("ready_low_when_full", 64'(host_wr_ready), 64'd0);
            wr(32'h0000_0010, 32'h0000_0100 + 32'(i), i < 8);
        end
        check("overflow_set", 64'(overflow_err), 64'd1);
        check("overflow_level", 64'(fifo_level), 64'd8);
        err_clr = 1'b1;
        wr(32'h0000_0010, 32'h0000_0199, 1'b0);
        check("overflow_beats_clear", 64'(overflow_err), 64'd1);
        tick();
        err_clr = 1'b0;
        check("overflow_cleared", 64'(overflow_err), 64'd0);

        // Reset during WAIT_RSP with four entries left behind
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++)
            wr(32'h0000_0010, 32'h0000_0200 + 32'(i), 1'b1);
        np = pulse_cnt;
        dac_done = 1'b1;
        tick();
        dac_done = 1'b0;
        wait_pulse(np + 1, 20);
        repeat (3) tick();
        check("midxfer_level", 64'(fifo_level), 64'd4);
        rst = 1'b1;
        sb.delete();
        #1;
        check_reset_outputs("midxfer_reset");
        tick();
        rst = 1'b0;
        np = pulse_cnt;
        wr(32'h0000_0010, 32'h0000_0300, 1'b1);
        repeat (30) tick();
        check("post_reset_waits_dac_done", 64'(pulse_cnt), 64'(np));
        dac_done = 1'b1;
        tick();
        dac_done = 1'b0;
        wait_pulse(np + 1, 20);
        respond(32'hC0DE_0300, 1);
        check("post_reset_rsp", 64'(last_rsp), 64'hC0DE_0300);
        repeat (4) tick();
        check("sb_empty_at_end", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
